mem_sram_controller: RTL and testbench
======================================

Name: mem_sram_controller

Overview:
- Sequences one 32-bit data-memory access from the MEM stage as two 16-bit accesses to an external asynchronous SRAM.
- Sits between the MEM stage's memory read/write enables and the SRAM pins.
- Drives ready_out low while an access is in progress.
- The processor inverts ready_out into a pipeline-wide freeze, stalling IF through MEM until the access completes.

Parameters:
WAIT_CYCLES, 1, extra cycles each SRAM half-access is held (phase length = WAIT_CYCLES+1 cycles); legal range 0..15
ADDR_BASE, 1024, byte address mapped to SRAM word 0; subtracted before word indexing
SRAM_AW, 18, SRAM address width (16-bit word address)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
mem_r_en_in  input  1  MEM-stage load request; held until ready_out=1
mem_w_en_in  input  1  MEM-stage store request; held until ready_out=1
address_in  input  32  byte address (ALU result)
write_data_in  input  32  store data (val_rm)
read_data_out  output  32  load result, registered
ready_out  output  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline
sram_addr_out  output  SRAM_AW  SRAM half-word address
sram_dq_out  output  16  write data to SRAM pads
sram_dq_oe_out  output  1  pad output enable (1 = drive sram_dq_out)
sram_dq_in  input  16  data from SRAM pads
sram_we_n_out  output  1  SRAM write strobe, active-low
sram_oe_n_out  output  1  SRAM output enable, active-low

Behaviour:
- Request: req = mem_r_en_in | mem_w_en_in. If both are asserted, the request is a write.
- Word index: w = (address_in - ADDR_BASE) >> 2, truncated to SRAM_AW-1 bits.
- Low half-word: SRAM address {w,0}, data bits [15:0].
- High half-word: SRAM address {w,1}, data bits [31:16].
- States: IDLE, LO, HI, DONE. A phase counter cnt counts 0..WAIT_CYCLES.
- IDLE:
  - If req, latch w, write_data_in and is_write; go to LO with cnt=0.
  - If no req, stay in IDLE.
  - While in IDLE, all SRAM strobes are inactive and sram_dq_oe_out=0.
- LO / HI:
  - sram_addr_out = latched low/high address.
  - Write: sram_dq_oe_out=1 and sram_dq_out = latched low/high half.
  - Write strobe: sram_we_n_out=0 in cycles with cnt>=1. When WAIT_CYCLES=0, it is 0 in the single cycle.
  - Read: sram_oe_n_out=0 for the whole phase. On the cycle with cnt==WAIT_CYCLES, capture sram_dq_in into read_data_out[15:0] (LO) or [31:16] (HI).
  - At cnt==WAIT_CYCLES, LO goes to HI and HI goes to DONE, with cnt reset to 0. Otherwise cnt increments.
- DONE:
  - Strobes inactive; go to IDLE unconditionally.
  - Inputs are not sampled this cycle, so the still-held request is not restarted.
- ready_out (combinational) = (state==IDLE & ~req) | (state==DONE).
- Latency: a request first seen in IDLE at cycle 0 raises ready_out at cycle 2*(WAIT_CYCLES+1)+1. With WAIT_CYCLES=1, ready is low for cycles 0..4 and high in cycle 5.
- Input changes after latching are ignored until return to IDLE.
- read_data_out holds its last value until a read overwrites it. Writes never modify it.
- Reset (asynchronous, any state):
  - state=IDLE, cnt=0, latched address/data=0, read_data_out=0.
  - Outputs: sram_addr_out=0, sram_dq_out=0, sram_dq_oe_out=0, sram_we_n_out=1, sram_oe_n_out=1.
  - An in-flight access is abandoned with no completion pulse.
- SRAM outputs decode from state and latched registers only, so they are glitch-free relative to input changes.

Test Plan:
- Hold rst=0, then release with no requests -> ready_out=1 every cycle; we_n=1, oe_n=1, dq_oe=0, read_data_out=0.
- Write 0x12345678 to address 1024 (WAIT_CYCLES=1) -> cycles 1-2: addr 0, dq 0x5678, we_n low in cycle 2 only. Cycles 3-4: addr 1, dq 0x1234, we_n low in cycle 4. ready_out=0 for cycles 0-4, ready_out=1 in cycle 5. No re-access in cycle 6.
- Read address 1024 with an SRAM model holding the prior write -> oe_n low cycles 1-4; read_data_out=0x12345678 from cycle 5; ready_out high in cycle 5 only while the request is held.
- Read address 1032 with WAIT_CYCLES=0 -> SRAM addresses 4 then 5; ready_out rises at cycle 3.
- Assert mem_r_en_in and mem_w_en_in together -> write sequence; oe_n stays 1 and read_data_out is unchanged.
- Assert rst low during HI of a write -> same cycle: we_n=1, dq_oe=0, state IDLE. After release with the request still held, a fresh full access starts from LO.

Source files
------------

// File: rtl/mem_sram_controller.sv
// rtl/mem_sram_controller.sv - sequences a 32-bit MEM-stage access as two 16-bit async SRAM accesses
module mem_sram_controller #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic [31:0]        address_in,
  input  logic [31:0]        write_data_in,
  output logic [31:0]        read_data_out,
  output logic               ready_out,
  output logic [SRAM_AW-1:0] sram_addr_out,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n_out,
  output logic               sram_oe_n_out
);

  localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] LP_BASE = 32'(ADDR_BASE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;
  logic [SRAM_AW-2:0] r_word;
  logic [31:0]        r_wdata;
  logic               r_is_write;
  logic [31:0]        r_rdata;

  logic               w_req;
  logic               w_last;
  logic               w_latch;
  logic               w_strobe;
  logic [31:0]        w_offset;
  logic [SRAM_AW-2:0] w_word;
  logic               w_unused;

  assign w_req    = mem_r_en_in | mem_w_en_in;
  assign w_offset = address_in - LP_BASE;
  assign w_word   = w_offset[SRAM_AW:2];
  // Byte-lane bits and address bits beyond the SRAM are intentionally dropped.
  assign w_unused = &{1'b0, w_offset[31:SRAM_AW+1], w_offset[1:0]};
  assign w_last   = (r_cnt == LP_WAIT);
  assign w_latch  = (r_state == S_IDLE) && w_req;
  // Write strobe waits one cycle for address setup, unless the phase is a single cycle.
  assign w_strobe = (r_cnt != 4'd0) || (WAIT_CYCLES == 0);

  assign ready_out     = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
  assign read_data_out = r_rdata;

  // State and phase counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latch the request in IDLE so later input changes cannot disturb the access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word     <= '0;
      r_wdata    <= 32'd0;
      r_is_write <= 1'b0;
    end else if (w_latch) begin
      r_word     <= w_word;
      r_wdata    <= write_data_in;
      r_is_write <= mem_w_en_in;
    end
  end

  // Capture each read half on the last cycle of its phase; writes leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
    end else if (!r_is_write && w_last) begin
      if (r_state == S_LO) begin
        r_rdata[15:0] <= sram_dq_in;
      end else if (r_state == S_HI) begin
        r_rdata[31:16] <= sram_dq_in;
      end
    end
  end

  // Next-state logic and SRAM pin decode from state and latched registers only.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    sram_addr_out  = '0;
    sram_dq_out    = 16'd0;
    sram_dq_oe_out = 1'b0;
    sram_we_n_out  = 1'b1;
    sram_oe_n_out  = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_LO;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_LO: begin
        sram_addr_out = {r_word, 1'b0};
        if (r_is_write) begin
          sram_dq_oe_out = 1'b1;
          sram_dq_out    = r_wdata[15:0];
          sram_we_n_out  = !w_strobe;
        end else begin
          sram_oe_n_out = 1'b0;
        end
        if (w_last) begin
          w_state_nxt = S_HI;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_HI: begin
        sram_addr_out = {r_word, 1'b1};
        if (r_is_write) begin
          sram_dq_oe_out = 1'b1;
          sram_dq_out    = r_wdata[31:16];
          sram_we_n_out  = !w_strobe;
        end else begin
          sram_oe_n_out = 1'b0;
        end
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_sram_controller.sv
// tb/tb_mem_sram_controller.sv - directed scoreboard bench for mem_sram_controller
module tb_mem_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        r_en1, w_en1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ready1, dq_oe1, we_n1, oe_n1;
  logic [17:0] saddr1;
  logic [15:0] dq1, dqin1;

  logic        r_en0, w_en0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, dq_oe0, we_n0, oe_n0;
  logic [17:0] saddr0;
  logic [15:0] dq0, dqin0;

  logic [15:0] mem1 [0:255];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  mem_sram_controller #(.WAIT_CYCLES(1), .ADDR_BASE(1024), .SRAM_AW(18)) u_dut1 (
    .clk(clk), .rst(rst),
    .mem_r_en_in(r_en1), .mem_w_en_in(w_en1),
    .address_in(addr1), .write_data_in(wdata1),
    .read_data_out(rdata1), .ready_out(ready1),
    .sram_addr_out(saddr1), .sram_dq_out(dq1), .sram_dq_oe_out(dq_oe1),
    .sram_dq_in(dqin1), .sram_we_n_out(we_n1), .sram_oe_n_out(oe_n1)
  );

  mem_sram_controller #(.WAIT_CYCLES(0), .ADDR_BASE(1024), .SRAM_AW(18)) u_dut0 (
    .clk(clk), .rst(rst),
    .mem_r_en_in(r_en0), .mem_w_en_in(w_en0),
    .address_in(addr0), .write_data_in(wdata0),
    .read_data_out(rdata0), .ready_out(ready0),
    .sram_addr_out(saddr0), .sram_dq_out(dq0), .sram_dq_oe_out(dq_oe0),
    .sram_dq_in(dqin0), .sram_we_n_out(we_n0), .sram_oe_n_out(oe_n0)
  );

  // SRAM model for the WAIT_CYCLES=1 instance: write on edge while strobe low.
  always @(posedge clk) begin
    if (!we_n1) mem1[saddr1[7:0]] <= dq1;
  end
  assign dqin1 = mem1[saddr1[7:0]];
  // Fixed-pattern ROM for the WAIT_CYCLES=0 instance.
  assign dqin0 = 16'hA000 | {8'd0, saddr0[7:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed 0x%0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    r_en1 = 0; w_en1 = 0; addr1 = 0; wdata1 = 0;
    r_en0 = 0; w_en0 = 0; addr0 = 0; wdata0 = 0;

    // Reset held, then released with no requests.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_ready1", ready1, 1'b1);
      chk("rst_we_n1", we_n1, 1'b1);
      chk("rst_oe_n1", oe_n1, 1'b1);
      chk("rst_dq_oe1", dq_oe1, 1'b0);
      chk("rst_rdata1", rdata1, 32'd0);
      chk("rst_ready0", ready0, 1'b1);
      chk("rst_rdata0", rdata0, 32'd0);
    end

    // Write 0x12345678 to 1024.
    @(posedge clk); #1;
    w_en1 = 1; addr1 = 32'd1024; wdata1 = 32'h12345678;
    for (int c = 0; c <= 5; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("wr_ready", ready1, c == 5);
      chk("wr_we_n", we_n1, !(c == 2 || c == 4));
      chk("wr_dq_oe", dq_oe1, c >= 1 && c <= 4);
      chk("wr_oe_n", oe_n1, 1'b1);
      if (c >= 1 && c <= 4) begin
        chk("wr_addr", saddr1, (c <= 2) ? 32'd0 : 32'd1);
        chk("wr_dq", dq1, (c <= 2) ? 32'h5678 : 32'h1234);
      end
    end
    @(posedge clk); #1;
    w_en1 = 0; addr1 = 32'hFFFF_FFFF; wdata1 = 32'hDEAD_DEAD;
    for (int c = 6; c <= 7; c++) begin
      @(negedge clk);
      chk("wr_post_ready", ready1, 1'b1);
      chk("wr_post_dq_oe", dq_oe1, 1'b0);
      chk("wr_post_we_n", we_n1, 1'b1);
      @(posedge clk); #1;
    end

    // Read back from 1024.
    r_en1 = 1; addr1 = 32'd1024;
    exp_q.push_back(32'h12345678);
    for (int c = 0; c <= 5; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("rd_ready", ready1, c == 5);
      chk("rd_oe_n", oe_n1, !(c >= 1 && c <= 4));
      chk("rd_we_n", we_n1, 1'b1);
      chk("rd_dq_oe", dq_oe1, 1'b0);
      if (c == 1) chk("rd_addr_lo", saddr1, 32'd0);
      if (c == 3) chk("rd_addr_hi", saddr1, 32'd1);
      if (c == 3) chk("rd_half", rdata1, 32'h00005678);
      if (c == 5) pop_chk("rd_data", rdata1);
    end
    @(posedge clk); #1;
    r_en1 = 0;
    @(negedge clk);
    chk("rd_hold", rdata1, 32'h12345678);
    chk("rd_post_oe_n", oe_n1, 1'b1);

    // WAIT_CYCLES=0 read from 1032.
    @(posedge clk); #1;
    r_en0 = 1; addr0 = 32'd1032;
    exp_q.push_back(32'hA005A004);
    for (int c = 0; c <= 3; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("w0_ready", ready0, c == 3);
      chk("w0_oe_n", oe_n0, !(c == 1 || c == 2));
      chk("w0_we_n", we_n0, 1'b1);
      chk("w0_dq_oe", dq_oe0, 1'b0);
      if (c == 1) chk("w0_addr_lo", saddr0, 32'd4);
      if (c == 2) chk("w0_addr_hi", saddr0, 32'd5);
      if (c == 3) pop_chk("w0_data", rdata0);
    end
    @(posedge clk); #1;
    r_en0 = 0;

    // Read and write asserted together behave as a write.
    r_en1 = 1; w_en1 = 1; addr1 = 32'd1028; wdata1 = 32'hCAFEF00D;
    for (int c = 0; c <= 5; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("both_ready", ready1, c == 5);
      chk("both_oe_n", oe_n1, 1'b1);
      chk("both_we_n", we_n1, !(c == 2 || c == 4));
      chk("both_dq_oe", dq_oe1, c >= 1 && c <= 4);
      chk("both_rdata", rdata1, 32'h12345678);
      if (c == 1) chk("both_lo", {14'd0, saddr1, dq1}, {14'd0, 18'd2, 16'hF00D});
      if (c == 3) chk("both_hi", {14'd0, saddr1, dq1}, {14'd0, 18'd3, 16'hCAFE});
    end
    @(posedge clk); #1;
    r_en1 = 0; w_en1 = 0;
    @(negedge clk);
    chk("both_mem", {mem1[3], mem1[2]}, 32'hCAFEF00D);

    // Reset during HI of a write, request held through and after reset.
    @(posedge clk); #1;
    w_en1 = 1; addr1 = 32'd1024; wdata1 = 32'h0BADBEEF;
    for (int c = 0; c <= 3; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      @(negedge clk);
    end
    chk("abort_pre_addr", saddr1, 32'd1);
    chk("abort_pre_dq_oe", dq_oe1, 1'b1);
    #1 rst = 0;
    #1;
    chk("abort_we_n", we_n1, 1'b1);
    chk("abort_dq_oe", dq_oe1, 1'b0);
    chk("abort_ready", ready1, 1'b0);
    chk("abort_addr", saddr1, 32'd0);
    chk("abort_rdata", rdata1, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_hold_dq_oe", dq_oe1, 1'b0);
    chk("abort_hold_ready", ready1, 1'b0);
    #1 rst = 1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("redo_ready", ready1, c == 5);
      chk("redo_we_n", we_n1, !(c == 2 || c == 4));
      chk("redo_dq_oe", dq_oe1, c >= 1 && c <= 4);
      if (c == 1) chk("redo_lo", {14'd0, saddr1, dq1}, {14'd0, 18'd0, 16'hBEEF});
      if (c == 3) chk("redo_hi", {14'd0, saddr1, dq1}, {14'd0, 18'd1, 16'h0BAD});
    end
    @(posedge clk); #1;
    w_en1 = 0;
    @(negedge clk);
    chk("redo_mem", {mem1[1], mem1[0]}, 32'h0BADBEEF);
    chk("redo_post_ready", ready1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
